// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's instruction, data and
// memory ports.
//   adr    : address, master -> slave
//   dat_m  : write data, master -> slave
//   dat_s  : read data, slave -> master
//   we/sel : write enable / byte selects, master -> slave
//   cyc/stb: cycle / strobe, master -> slave
//   ack/err: termination, slave -> master
interface wb_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_m;
  logic [DW-1:0] dat_s;
  logic          we;
  logic [3:0]    sel;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_m, we, sel, cyc, stb,
    input  dat_s, ack, err
  );

  modport slave (
    input  adr, dat_m, we, sel, cyc, stb,
    output dat_s, ack, err
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-into-one Wishbone arbiter: the core's instruction port (iwb) and data
// port (dwb) share one unified-memory master port (mwb). Round-robin on ties,
// grants are locked until ack/err/abort, and a watchdog forces an error on a
// granted transaction that the memory never terminates.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   iwb        : instruction fetch bus (slave side, read-only use)
//   dwb        : data bus (slave side)
//   mwb        : memory bus (master side)
//   grant_o    : current grant, 00 none / 01 ibus / 10 dbus
//   timeout_o  : one-cycle pulse when the watchdog fires
module wb_mem_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_mem_arbiter_if.slave      iwb,
  wb_mem_arbiter_if.slave      dwb,
  wb_mem_arbiter_if.master     mwb,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam logic            WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYCLES);

  // Encoding doubles as the grant_o code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic            last_d, last_d_nxt;   // 1: dbus held the last grant
  logic [TO_W-1:0] wd_cnt, wd_cnt_nxt;

  logic req_i, req_d, resp;
  logic g_cyc, g_stb, wd_fire;

  assign req_i = iwb.cyc & iwb.stb;
  assign req_d = dwb.cyc & dwb.stb;
  assign resp  = mwb.ack | mwb.err;

  // State register; reset leaves ibus as last owner so dbus wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Arbitration, master mux, response routing and watchdog.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    wd_cnt_nxt = wd_cnt;
    g_cyc      = 1'b0;
    g_stb      = 1'b0;
    wd_fire    = 1'b0;
    grant_o    = 2'b00;
    timeout_o  = 1'b0;

    mwb.adr    = '0;
    mwb.dat_m  = '0;
    mwb.we     = 1'b0;
    mwb.sel    = 4'h0;
    mwb.cyc    = 1'b0;
    mwb.stb    = 1'b0;

    // Read data is broadcast; only ack/err are steered.
    iwb.dat_s  = mwb.dat_s;
    dwb.dat_s  = mwb.dat_s;
    iwb.ack    = 1'b0;
    iwb.err    = 1'b0;
    dwb.ack    = 1'b0;
    dwb.err    = 1'b0;

    unique case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (req_i && req_d) begin
          state_nxt = last_d ? GNT_I : GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end else if (req_d) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        grant_o = 2'b01;
        g_cyc   = iwb.cyc;
        g_stb   = iwb.stb;
        mwb.adr = iwb.adr;
        mwb.sel = 4'hF;
      end
      GNT_D: begin
        grant_o   = 2'b10;
        g_cyc     = dwb.cyc;
        g_stb     = dwb.stb;
        mwb.adr   = dwb.adr;
        mwb.dat_m = dwb.dat_m;
        mwb.we    = dwb.we;
        mwb.sel   = dwb.sel;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == GNT_I || state == GNT_D) begin
      // A real ack/err beats the watchdog; an aborted cycle gets no error.
      wd_fire = WD_EN && !resp && g_cyc && (wd_cnt == WD_LIMIT);

      if (resp || !g_cyc || wd_fire) begin
        state_nxt  = IDLE;
        last_d_nxt = (state == GNT_D);
      end else if (WD_EN) begin
        wd_cnt_nxt = wd_cnt + TO_W'(1);
      end

      // Drop the strobe on a watchdog fire so memory sees the cycle end.
      mwb.cyc   = g_cyc & g_stb & ~wd_fire;
      mwb.stb   = g_cyc & g_stb & ~wd_fire;
      timeout_o = wd_fire;

      iwb.ack = (state == GNT_I) & mwb.ack;
      iwb.err = (state == GNT_I) & (mwb.err | wd_fire);
      dwb.ack = (state == GNT_D) & mwb.ack;
      dwb.err = (state == GNT_D) & (mwb.err | wd_fire);
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_wb_mem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 4;
  localparam int unsigned TO_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.AW(AW), .DW(DW)) iwb ();
  wb_mem_arbiter_if #(.AW(AW), .DW(DW)) dwb ();
  wb_mem_arbiter_if #(.AW(AW), .DW(DW)) mwb ();

  wb_mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO), .TO_W(TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iwb       (iwb),
    .dwb       (dwb),
    .mwb       (mwb),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  // Stimulus, indexed by port: 0 = nobody (always idle), 1 = ibus, 2 = dbus.
  logic          p_cyc [0:2];
  logic          p_stb [0:2];
  logic [AW-1:0] p_adr [0:2];
  logic [DW-1:0] d_dat;
  logic          d_we;
  logic [3:0]    d_sel;
  logic          m_ack, m_err;
  logic [DW-1:0] m_dat;
  bit            react;          // memory acks one cycle after seeing stb

  // Reference model: owner of the memory, previous owner, cycles waited.
  int own, last, waited;

  // Observations for directed checks.
  int            obs_iack, obs_dack, obs_derr, obs_to, cyc_n, gnt_cyc, to_cyc;
  logic          prev_stb, prev_ack;
  logic [1:0]    prev_grant;
  logic [1:0]    gq[$];
  logic [DW-1:0] seen_idat;
  logic [AW-1:0] seen_adr;
  logic [DW-1:0] seen_dat;
  logic          seen_we;
  logic [3:0]    seen_sel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, compare against the model, advance model and DUT.
  task automatic step();
    logic          resp, fire, e_cyc;
    logic [3:0]    e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    int            n_own, n_last, n_wait;

    if (react) m_ack = prev_stb && !prev_ack;
    iwb.adr = p_adr[1]; iwb.cyc = p_cyc[1]; iwb.stb = p_stb[1];
    iwb.dat_m = '0; iwb.we = 1'b0; iwb.sel = 4'h0;
    dwb.adr = p_adr[2]; dwb.cyc = p_cyc[2]; dwb.stb = p_stb[2];
    dwb.dat_m = d_dat; dwb.we = d_we; dwb.sel = d_sel;
    mwb.ack = m_ack; mwb.err = m_err; mwb.dat_s = m_dat;
    #2;

    resp  = m_ack | m_err;
    fire  = (own != 0) && (TO != 0) && (waited == int'(TO)) && !resp && p_cyc[own];
    e_cyc = p_cyc[own] && p_stb[own] && !fire;
    e_adr = p_adr[own];
    e_dat = (own == 2) ? d_dat : '0;
    e_sel = (own == 1) ? 4'hF : ((own == 2) ? d_sel : 4'h0);

    check("grant",   64'(grant),     64'(own));
    check("mwb_cyc", 64'(mwb.cyc),   64'(e_cyc));
    check("mwb_stb", 64'(mwb.stb),   64'(e_cyc));
    check("mwb_adr", 64'(mwb.adr),   64'(e_adr));
    check("mwb_dat", 64'(mwb.dat_m), 64'(e_dat));
    check("mwb_we",  64'(mwb.we),    64'((own == 2) && d_we));
    check("mwb_sel", 64'(mwb.sel),   64'(e_sel));
    check("iwb_ack", 64'(iwb.ack),   64'((own == 1) && m_ack));
    check("iwb_err", 64'(iwb.err),   64'((own == 1) && (m_err || fire)));
    check("dwb_ack", 64'(dwb.ack),   64'((own == 2) && m_ack));
    check("dwb_err", 64'(dwb.err),   64'((own == 2) && (m_err || fire)));
    check("timeout", 64'(timeout),   64'(fire));
    check("iwb_dat", 64'(iwb.dat_s), 64'(m_dat));
    check("dwb_dat", 64'(dwb.dat_s), 64'(m_dat));

    if (iwb.ack) begin obs_iack++; seen_idat = iwb.dat_s; end
    if (dwb.ack) begin
      obs_dack++;
      seen_adr = mwb.adr; seen_dat = mwb.dat_m; seen_we = mwb.we; seen_sel = mwb.sel;
    end
    if (dwb.err) obs_derr++;
    if (timeout) begin obs_to++; to_cyc = cyc_n; end
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      gq.push_back(grant);
      if (grant == 2'b10) gnt_cyc = cyc_n;
    end
    prev_grant = grant;
    prev_stb   = mwb.stb;
    prev_ack   = m_ack;

    // Spec rules: free memory goes to the sole requester, or on a tie to
    // whoever did not own it last; an owner keeps it until ack/err, abort
    // or the watchdog limit.
    n_own = own; n_last = last; n_wait = waited;
    if (own == 0) begin
      n_wait = 0;
      if (p_cyc[1] && p_stb[1] && p_cyc[2] && p_stb[2]) n_own = 3 - last;
      else if (p_cyc[1] && p_stb[1]) n_own = 1;
      else if (p_cyc[2] && p_stb[2]) n_own = 2;
    end else if (resp || !p_cyc[own] || fire) begin
      n_last = own;
      n_own  = 0;
    end else begin
      n_wait = waited + 1;
    end

    @(posedge clk);
    if (!rst_n) begin
      own = 0; last = 1; waited = 0;
    end else begin
      own = n_own; last = n_last; waited = n_wait;
    end
    cyc_n++;
    #1;
  endtask

  task automatic req(input int p, input logic on);
    p_cyc[p] = on;
    p_stb[p] = on;
  endtask

  task automatic idle(input int n);
    req(1, 1'b0); req(2, 1'b0);
    react = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    repeat (n) step();
  endtask

  logic [1:0] exp_order [0:5];

  initial begin
    for (int i = 0; i < 3; i++) begin
      p_cyc[i] = 1'b0; p_stb[i] = 1'b0; p_adr[i] = '0;
    end
    d_dat = '0; d_we = 1'b0; d_sel = 4'h0;
    m_ack = 1'b0; m_err = 1'b0; m_dat = '0; react = 1'b0;
    prev_stb = 1'b0; prev_ack = 1'b0; prev_grant = 2'b00;
    obs_iack = 0; obs_dack = 0; obs_derr = 0; obs_to = 0;
    cyc_n = 0; gnt_cyc = 0; to_cyc = 0;
    seen_idat = '0; seen_adr = '0; seen_dat = '0; seen_we = 1'b0; seen_sel = 4'h0;
    exp_order[0] = 2'b10; exp_order[1] = 2'b01; exp_order[2] = 2'b10;
    exp_order[3] = 2'b01; exp_order[4] = 2'b10; exp_order[5] = 2'b01;

    // Reset held with both ports requesting and a stray memory ack.
    rst_n = 1'b0;
    req(1, 1'b1); req(2, 1'b1); m_ack = 1'b1;
    p_adr[1] = 32'h0000_0200; p_adr[2] = 32'h0000_0400;
    @(posedge clk); #1;
    own = 0; last = 1; waited = 0;
    repeat (2) step();
    check("rst_acks", 64'(obs_iack + obs_dack), 64'd0);

    // Continuous contention from reset release: D first, then alternate.
    rst_n = 1'b1; m_ack = 1'b0; react = 1'b1;
    for (int k = 0; k < 60 && gq.size() < 6; k++) step();
    check("rr_count", 64'(gq.size()), 64'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(exp_order[i]));
    idle(3);

    // Single instruction fetch.
    obs_iack = 0; obs_dack = 0;
    p_adr[1] = 32'h0000_0100; m_dat = 32'h0000_0013; react = 1'b1;
    req(1, 1'b1);
    step();
    check("ifetch_lat", 64'(mwb.stb), 64'd1);
    for (int k = 0; k < 10 && obs_iack == 0; k++) step();
    req(1, 1'b0);
    idle(2);
    check("ifetch_iack", 64'(obs_iack), 64'd1);
    check("ifetch_dat", 64'(seen_idat), 64'h13);
    check("ifetch_dack", 64'(obs_dack), 64'd0);

    // Abort one cycle after grant, memory acks late into IDLE.
    obs_iack = 0;
    req(1, 1'b1); step(); step();
    req(1, 1'b0); step();
    m_ack = 1'b1; step();
    m_ack = 1'b0; step();
    check("abort_iack", 64'(obs_iack), 64'd0);

    // Data write with iwb contending; dbus wins since ibus owned last.
    obs_iack = 0; obs_dack = 0;
    p_adr[2] = 32'h0000_1000; d_dat = 32'h0000_0001; d_sel = 4'b0011; d_we = 1'b1;
    req(1, 1'b1); req(2, 1'b1); react = 1'b1;
    for (int k = 0; k < 20 && obs_dack == 0; k++) step();
    check("wr_dack", 64'(obs_dack), 64'd1);
    check("wr_iack", 64'(obs_iack), 64'd0);
    check("wr_adr", 64'(seen_adr), 64'h1000);
    check("wr_dat", 64'(seen_dat), 64'h1);
    check("wr_we", 64'(seen_we), 64'd1);
    check("wr_sel", 64'(seen_sel), 64'h3);
    req(2, 1'b0); d_we = 1'b0;
    for (int k = 0; k < 20 && obs_iack == 0; k++) step();
    check("wr_iack_after", 64'(obs_iack), 64'd1);
    idle(2);

    // Watchdog on a dbus read the memory ignores; ibus waits behind it.
    obs_to = 0; obs_derr = 0; gq.delete();
    p_adr[2] = 32'h0000_2000; p_adr[1] = 32'h0000_0104;
    req(2, 1'b1);
    for (int k = 0; k < 20 && gq.size() < 2; k++) begin
      if (k == 2) req(1, 1'b1);
      if (obs_to != 0) req(2, 1'b0);
      step();
    end
    check("wd_pulses", 64'(obs_to), 64'd1);
    check("wd_derr", 64'(obs_derr), 64'd1);
    check("wd_delay", 64'(to_cyc - gnt_cyc), 64'd4);
    check("wd_next_grant", 64'((gq.size() >= 2) ? gq[1] : 2'b00), 64'h1);
    react = 1'b1; obs_iack = 0;
    for (int k = 0; k < 20 && obs_iack == 0; k++) step();
    idle(2);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int p = 1; p < 3; p++) begin
        p_cyc[p] = ($urandom % 8) != 0;
        p_stb[p] = p_cyc[p] && (($urandom % 6) != 0);
        p_adr[p] = AW'($urandom);
      end
      d_dat = DW'($urandom); d_we = 1'($urandom); d_sel = 4'($urandom);
      m_ack = ($urandom % 4) == 0;
      m_err = ($urandom % 16) == 0;
      m_dat = DW'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
